// File: rtl/player_arbiter.sv
// Shares one music player between MSC_N prioritised requesters (index 0 highest), with a
// bounded play time and an enforced silent gap. Define PLAYER_ARB_PEND_EN to queue losing requests.
module player_arbiter #(
   parameter int unsigned MSC_N   = 4,
   parameter int unsigned PLAY_S  = 30,
   parameter int unsigned GAP_CYC = 16
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             sec_tick,
   input  logic [MSC_N-1:0] req,
   input  logic             stop,
   output logic [MSC_N-1:0] start,
   output logic [MSC_N-1:0] grant,
   output logic             busy,
   output logic             done,
   output logic             done_to
);

   typedef enum logic [2:0] {
      StIdle = 3'b001,
      StPlay = 3'b010,
      StGap  = 3'b100
   } state_e;

   localparam logic [7:0]       SecLast = 8'(PLAY_S - 1);
   localparam logic [7:0]       GapLast = 8'(GAP_CYC - 1);
   localparam logic [MSC_N-1:0] One     = MSC_N'(1);
`ifdef PLAYER_ARB_PEND_EN
   localparam bit PendEn = 1'b1;
`else
   localparam bit PendEn = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [MSC_N-1:0] start_q, start_d;
   logic [MSC_N-1:0] grant_q, grant_d;
   logic [MSC_N-1:0] pend_q, pend_d, pend_nxt;
   logic [7:0]       sec_cnt_q, sec_cnt_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             done_to_q, done_to_d;

   logic [MSC_N-1:0] cand, cand_win, req_win;
   logic             preempt, repeat_req, timeout;

   always_comb begin
      cand       = req | pend_q;
      // Isolate lowest set bit: x & -x.
      cand_win   = cand & (~cand + One);
      req_win    = req & (~req + One);
      preempt    = |(req & (start_q - One));
      repeat_req = |(req & start_q);
      timeout    = sec_tick && (sec_cnt_q == SecLast);
   end

   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      sec_cnt_d = sec_cnt_q;
      gap_cnt_d = gap_cnt_q;
      pend_nxt  = pend_q | req;
      done_d    = 1'b0;
      done_to_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|cand) begin
               state_d   = StPlay;
               start_d   = cand_win;
               sec_cnt_d = 8'd0;
               pend_nxt  = cand & ~cand_win;
            end
         end
         StPlay: begin
            if (stop) begin
               state_d   = StGap;
               start_d   = '0;
               gap_cnt_d = 8'd0;
               done_d    = 1'b1;
            end else if (preempt) begin
               // Pre-empted requester is dropped, not re-queued.
               start_d   = req_win;
               sec_cnt_d = 8'd0;
               pend_nxt  = pend_q | (req & ~req_win);
            end else if (repeat_req) begin
               sec_cnt_d = 8'd0;
               pend_nxt  = pend_q | (req & ~start_q);
            end else if (timeout) begin
               state_d   = StGap;
               start_d   = '0;
               gap_cnt_d = 8'd0;
               done_d    = 1'b1;
               done_to_d = 1'b1;
            end else if (sec_tick) begin
               sec_cnt_d = sec_cnt_q + 8'd1;
            end
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               if (|cand) begin
                  state_d   = StPlay;
                  start_d   = cand_win;
                  sec_cnt_d = 8'd0;
                  pend_nxt  = cand & ~cand_win;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            start_d = '0;
         end
      endcase

      pend_d  = PendEn ? pend_nxt : '0;
      grant_d = (state_d == StPlay) ? start_d : '0;
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q   <= StIdle;
         start_q   <= '0;
         grant_q   <= '0;
         pend_q    <= '0;
         sec_cnt_q <= 8'd0;
         gap_cnt_q <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_to_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         grant_q   <= grant_d;
         pend_q    <= pend_d;
         sec_cnt_q <= sec_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_to_q <= done_to_d;
      end
   end

   assign start   = start_q;
   assign grant   = grant_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_to = done_to_q;

endmodule

// File: tb/tb_player_arbiter.sv
// Self-checking bench for player_arbiter (MSC_N=4, PLAY_S=3, GAP_CYC=4); per-cycle vectors
// with a scoreboard of expected outputs. Pending expectations follow PLAYER_ARB_PEND_EN.
module tb_player_arbiter;

   logic       sysclk = 1'b0;
   logic       rst = 1'b0;
   logic       sec_tick = 1'b0;
   logic [3:0] req = '0;
   logic       stop = 1'b0;
   logic [3:0] start, grant;
   logic       busy, done, done_to;

   player_arbiter #(.MSC_N(4), .PLAY_S(3), .GAP_CYC(4)) dut (
      .sysclk   (sysclk),
      .rst      (rst),
      .sec_tick (sec_tick),
      .req      (req),
      .stop     (stop),
      .start    (start),
      .grant    (grant),
      .busy     (busy),
      .done     (done),
      .done_to  (done_to)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] req;
      logic       stop;
      logic       tick;
      logic [3:0] e_start;
      logic       e_busy;
      logic       e_done;
      logic       e_to;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   function automatic vec_t mk(string nm, logic r, logic [3:0] rq, logic s, logic t,
                               logic [3:0] es, logic eb, logic ed, logic eto);
      vec_t v;
      v.name = nm; v.rst = r; v.req = rq; v.stop = s; v.tick = t;
      v.e_start = es; v.e_busy = eb; v.e_done = ed; v.e_to = eto;
      return v;
   endfunction

   // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
   task automatic step(input vec_t v);
      vec_t       w;
      logic [10:0] got, want;
      rst = v.rst; req = v.req; stop = v.stop; sec_tick = v.tick;
      exp_q.push_back(v);
      @(posedge sysclk);
      #1;
      w    = exp_q.pop_front();
      got  = {start, grant, busy, done, done_to};
      want = {w.e_start, w.e_start, w.e_busy, w.e_done, w.e_to};
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: start/grant/busy/done/done_to got %b %b %b %b %b want %b %b %b %b %b",
                    w.name, start, grant, busy, done, done_to,
                    w.e_start, w.e_start, w.e_busy, w.e_done, w.e_to);
   endtask

   task automatic s(string nm, logic r, logic [3:0] rq, logic sp, logic t,
                    logic [3:0] es, logic eb, logic ed, logic eto);
      step(mk(nm, r, rq, sp, t, es, eb, ed, eto));
   endtask

   task automatic gap3(string nm);
      for (int i = 0; i < 3; i++) s(nm, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);
   endtask

   initial begin
      // Reset, timeout
      tbl.push_back(mk("reset",      1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk("to_start",   0, 4'b0100, 0, 0, 4'b0100, 1, 0, 0));
      tbl.push_back(mk("to_tick1",   0, 4'b0000, 0, 1, 4'b0100, 1, 0, 0));
      tbl.push_back(mk("to_hold",    0, 4'b0000, 0, 0, 4'b0100, 1, 0, 0));
      tbl.push_back(mk("to_tick2",   0, 4'b0000, 0, 1, 4'b0100, 1, 0, 0));
      tbl.push_back(mk("to_done",    0, 4'b0000, 0, 1, 4'b0000, 1, 1, 1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk("to_gap", 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("to_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
      // Pre-emption restarts the time budget
      tbl.push_back(mk("pe_start",   0, 4'b1000, 0, 0, 4'b1000, 1, 0, 0));
      tbl.push_back(mk("pe_tick1",   0, 4'b0000, 0, 1, 4'b1000, 1, 0, 0));
      tbl.push_back(mk("pe_tick2",   0, 4'b0000, 0, 1, 4'b1000, 1, 0, 0));
      tbl.push_back(mk("pe_switch",  0, 4'b0001, 0, 0, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("pe_tick1b",  0, 4'b0000, 0, 1, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("pe_tick2b",  0, 4'b0000, 0, 1, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("pe_done",    0, 4'b0000, 0, 1, 4'b0000, 1, 1, 1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk("pe_gap", 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("pe_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
      // Stop, then stop ignored in IDLE
      tbl.push_back(mk("st_start",   0, 4'b0010, 0, 0, 4'b0010, 1, 0, 0));
      tbl.push_back(mk("st_done",    0, 4'b0000, 1, 0, 4'b0000, 1, 1, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk("st_gap", 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("st_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk("st_ign",     0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
      // Repeat request restarts the budget
      tbl.push_back(mk("rp_start",   0, 4'b0001, 0, 0, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("rp_tick1",   0, 4'b0000, 0, 1, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("rp_tick2",   0, 4'b0000, 0, 1, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("rp_again",   0, 4'b0001, 0, 0, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("rp_tick1b",  0, 4'b0000, 0, 1, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("rp_tick2b",  0, 4'b0000, 0, 1, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("rp_done",    0, 4'b0000, 0, 1, 4'b0000, 1, 1, 1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk("rp_gap", 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("rp_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Pending requests across a stop
      s("pd_start", 0, 4'b0001, 0, 0, 4'b0001, 1, 0, 0);
      s("pd_req",   0, 4'b0110, 0, 0, 4'b0001, 1, 0, 0);
      s("pd_stop",  0, 4'b0000, 1, 0, 4'b0000, 1, 1, 0);
      gap3("pd_gap");
`ifdef PLAYER_ARB_PEND_EN
      s("pd_next1", 0, 4'b0000, 0, 0, 4'b0010, 1, 0, 0);
      s("pd_tk1",   0, 4'b0000, 0, 1, 4'b0010, 1, 0, 0);
      s("pd_tk2",   0, 4'b0000, 0, 1, 4'b0010, 1, 0, 0);
      s("pd_to",    0, 4'b0000, 0, 1, 4'b0000, 1, 1, 1);
      gap3("pd_gap2");
      s("pd_next2", 0, 4'b0000, 0, 0, 4'b0100, 1, 0, 0);
      s("pd_stop2", 0, 4'b0000, 1, 0, 4'b0000, 1, 1, 0);
      gap3("pd_gap3");
      s("pd_idle",  0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
`else
      s("pd_idle",  0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
      s("pd_stay",  0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
`endif

      // Reset mid-song: no done, counters cleared
      s("rs_start", 0, 4'b0010, 0, 0, 4'b0010, 1, 0, 0);
      s("rs_tick",  0, 4'b0000, 0, 1, 4'b0010, 1, 0, 0);
      s("rs_rst",   1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
      s("rs_quiet", 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
      s("rs_again", 0, 4'b0010, 0, 0, 4'b0010, 1, 0, 0);
      s("rs_tk1",   0, 4'b0000, 0, 1, 4'b0010, 1, 0, 0);
      s("rs_tk2",   0, 4'b0000, 0, 1, 4'b0010, 1, 0, 0);
      s("rs_to",    0, 4'b0000, 0, 1, 4'b0000, 1, 1, 1);
      gap3("rs_gap");
      s("rs_idle",  0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
